// File: rtl/tristate_bus_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned width_min1(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  int unsigned w_k;

  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_k      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_k = (32'(i_ptr) + i) % NREQ;
      if (!o_valid && i_req[w_k]) begin
        o_valid       = 1'b1;
        o_idx         = PW'(w_k);
        o_onehot[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencing for one shared tri-state bus, with high-Z
// turnaround between owners and a bounded hold time under contention.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TURN    = 2,
  parameter int unsigned MAXHOLD = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ*DW-1:0] D_IN,
  output logic [NREQ-1:0]  GNT,
  output logic [DW-1:0]    BUS_I,
  output logic             BUS_T,
  output logic             BUSY
);

  localparam int unsigned PW = width_min1(NREQ);
  localparam int unsigned HW = width_min1(MAXHOLD);
  localparam int unsigned TW = width_min1(TURN);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [DW-1:0]   r_bus_i, w_bus_i_nxt;
  logic            r_bus_t, w_bus_t_nxt;
  logic            r_busy;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic [TW-1:0]   r_turn, w_turn_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;

  logic            w_arb;
  logic            w_release;
  logic [NREQ-1:0] w_pick_onehot;
  logic [PW-1:0]   w_pick_idx;
  logic            w_pick_valid;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .i_req    (REQ),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_bus_i_nxt = r_bus_i;
    w_bus_t_nxt = r_bus_t;
    w_hold_nxt  = r_hold;
    w_turn_nxt  = r_turn;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_arb       = 1'b0;
    w_release   = 1'b0;

    case (r_state)
      ST_IDLE: w_arb = 1'b1;
      ST_DRIVE: begin
        w_release = !REQ[r_owner] ||
                    ((r_hold == HOLD_LAST) && ((REQ & ~r_gnt) != '0));
        if (w_release) begin
          w_gnt_nxt   = '0;
          w_bus_t_nxt = 1'b1;
          w_bus_i_nxt = '0;
          w_turn_nxt  = TURN_LOAD;
          w_state_nxt = ST_TURN;
        end else begin
          w_bus_i_nxt = D_IN[32'(r_owner)*DW +: DW];
          if (r_hold != HOLD_LAST) w_hold_nxt = r_hold + HW'(1);
        end
      end
      ST_TURN: begin
        if (r_turn == '0) w_arb = 1'b1;
        else              w_turn_nxt = r_turn - TW'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_arb) begin
      if (w_pick_valid) begin
        w_gnt_nxt   = w_pick_onehot;
        w_bus_t_nxt = 1'b0;
        w_bus_i_nxt = D_IN[32'(w_pick_idx)*DW +: DW];
        w_hold_nxt  = '0;
        w_owner_nxt = w_pick_idx;
        w_ptr_nxt   = (w_pick_idx == PTR_LAST) ? '0 : w_pick_idx + PW'(1);
        w_state_nxt = ST_DRIVE;
      end else begin
        w_gnt_nxt   = '0;
        w_bus_t_nxt = 1'b1;
        w_bus_i_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_bus_i <= '0;
      r_bus_t <= 1'b1;
      r_busy  <= 1'b0;
      r_hold  <= '0;
      r_turn  <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_bus_i <= w_bus_i_nxt;
      r_bus_t <= w_bus_t_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_hold  <= w_hold_nxt;
      r_turn  <= w_turn_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  assign GNT   = r_gnt;
  assign BUS_I = r_bus_i;
  assign BUS_T = r_bus_t;
  assign BUSY  = r_busy;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter at NREQ=4, DW=8, TURN=2, MAXHOLD=4.
module tb_tristate_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = '0;
  logic [31:0] D_IN = '0;
  logic [3:0]  GNT;
  logic [7:0]  BUS_I;
  logic        BUS_T;
  logic        BUSY;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  tristate_bus_arbiter #(.NREQ(4), .DW(8), .TURN(2), .MAXHOLD(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .D_IN  (D_IN),
    .GNT   (GNT),
    .BUS_I (BUS_I),
    .BUS_T (BUS_T),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = '0;
    step();
    RST = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] gnt, input logic [7:0] bi,
                           input logic bt, input logic busy);
    check_eq({tag, "_gnt"},  32'(GNT),   32'(gnt));
    check_eq({tag, "_busi"}, 32'(BUS_I), 32'(bi));
    check_eq({tag, "_bust"}, 32'(BUS_T), 32'(bt));
    check_eq({tag, "_busy"}, 32'(BUSY),  32'(busy));
  endtask

  // Bus-safety invariants sampled mid-cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      check_eq("inv_onehot", 32'($countones(GNT) <= 1), 32'h1);
      check_eq("inv_t_vs_gnt", 32'(BUS_T), 32'(~|GNT));
      if (BUS_T) check_eq("inv_i_zero", 32'(BUS_I), 32'h0);
    end
  end

  initial begin
    int phase;
    int own;

    // 1: reset holds everything idle despite full requests
    RST  = 1'b1;
    REQ  = 4'b1111;
    D_IN = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      step();
      mon_en = 1'b1;
      check_out("t1_rst", 4'b0000, 8'h00, 1'b1, 1'b0);
    end
    RST = 1'b0;
    step();
    check_out("t1_first", 4'b0001, 8'hFF, 1'b0, 1'b1);

    // 2: single requester, drop, re-request through turnaround
    do_reset();
    REQ  = 4'b0001;
    D_IN = 32'h0000_00A5;
    step();
    check_out("t2_grant", 4'b0001, 8'hA5, 1'b0, 1'b1);
    D_IN[7:0] = 8'h5A;
    step();
    check_eq("t2_lag", 32'(BUS_I), 32'h5A);
    for (int c = 0; c < 3; c++) step();
    check_eq("t2_still", 32'(GNT), 32'h1);
    REQ = 4'b0000;
    step();
    check_out("t2_rel", 4'b0000, 8'h00, 1'b1, 1'b1);
    REQ = 4'b0001;
    step();
    check_out("t2_gap2", 4'b0000, 8'h00, 1'b1, 1'b1);
    step();
    check_out("t2_regrant", 4'b0001, 8'h5A, 1'b0, 1'b1);

    // 3: full contention rotates 0,1,2,3,0 with 4 drive + 2 gap cycles each
    do_reset();
    D_IN = {8'h43, 8'h32, 8'h21, 8'h10};
    REQ  = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      step();
      phase = c % 6;
      own   = (c / 6) % 4;
      if (phase < 4) begin
        check_eq("t3_gnt",  32'(GNT),   32'h1 << own);
        check_eq("t3_busi", 32'(BUS_I), 32'h10 + 32'(own) * 32'h11);
      end else begin
        check_eq("t3_gap_gnt", 32'(GNT), 32'h0);
        check_eq("t3_gap_t",   32'(BUS_T), 32'h1);
      end
      check_eq("t3_busy", 32'(BUSY), 32'h1);
    end

    // 4: sole requester is never cut off at MAXHOLD
    do_reset();
    D_IN = {8'h43, 8'h32, 8'h21, 8'h10};
    REQ  = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("t4_gnt",  32'(GNT),   32'h4);
      check_eq("t4_bust", 32'(BUS_T), 32'h0);
      check_eq("t4_busi", 32'(BUS_I), 32'h32);
    end

    // 5: contender arriving mid-hold forces release after 4 drive cycles
    do_reset();
    REQ = 4'b0001;
    step();
    step();
    REQ = 4'b0101;
    step();
    check_eq("t5_hold2", 32'(GNT), 32'h1);
    step();
    check_eq("t5_hold3", 32'(GNT), 32'h1);
    step();
    check_out("t5_rel", 4'b0000, 8'h00, 1'b1, 1'b1);
    step();
    check_out("t5_gap", 4'b0000, 8'h00, 1'b1, 1'b1);
    step();
    check_out("t5_next", 4'b0100, 8'h32, 1'b0, 1'b1);

    // 6: reset mid-drive idles the bus and restarts the pointer at 0
    do_reset();
    REQ = 4'b1000;
    step();
    check_eq("t6_own3", 32'(GNT), 32'h8);
    RST = 1'b1;
    REQ = 4'b1001;
    step();
    check_out("t6_rst", 4'b0000, 8'h00, 1'b1, 1'b0);
    RST = 1'b0;
    step();
    check_out("t6_ptr0", 4'b0001, 8'h10, 1'b0, 1'b1);

    // 6b: owner 1 leaves pointer at 2; reset must still favour requester 0
    do_reset();
    REQ = 4'b0010;
    step();
    check_eq("t6b_own1", 32'(GNT), 32'h2);
    RST = 1'b1;
    REQ = 4'b1001;
    step();
    check_out("t6b_rst", 4'b0000, 8'h00, 1'b1, 1'b0);
    RST = 1'b0;
    step();
    check_eq("t6b_ptr0", 32'(GNT), 32'h1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
